// File: rtl/fifo_wr_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_stream_adapter
// Purpose  : Write-side front end of the async FIFO. Turns a valid/ready
//            producer stream into the FIFO write strobe/data through a
//            2-entry skid buffer, so that s_ready is a pure state decode and
//            has no combinational path from wfull. Also keeps word, packet
//            and stall counters for the write side.
// Ports    : wclk, wrst_n          - write clock, async active-low reset
//            s_valid/s_data/s_last - producer stream in
//            s_ready               - adapter can take a word this cycle
//            wen, wfull            - drain enable, FIFO full (combinational)
//            winc, wdata           - FIFO write strobe and data
//            word_cnt, pkt_cnt     - words / last-words written (wrapping)
//            stall_cnt             - full-blocked cycles (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_stream_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  wen,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                state_q,     state_d;
    logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
    logic                  head_last_q, head_last_d;
    logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
    logic                  tail_last_q, tail_last_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q,  word_cnt_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q,   pkt_cnt_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

    logic w_accept;
    logic w_winc;
    logic w_stall;

    // s_ready depends on state only; wfull reaches winc but never s_ready.
    assign s_ready  = (state_q != ST_TWO);
    assign w_accept = s_valid & s_ready;
    assign w_winc   = (state_q != ST_EMPTY) & wen & ~wfull;
    assign w_stall  = (state_q != ST_EMPTY) & wen & wfull;

    assign winc      = w_winc;
    assign wdata     = head_data_q;
    assign word_cnt  = word_cnt_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;

        case (state_q)
            ST_EMPTY: begin
                if (w_accept) begin
                    state_d     = ST_ONE;
                    head_data_d = s_data;
                    head_last_d = s_last;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_winc) begin
                    // Head is blocked: park the new word in the skid slot.
                    state_d     = ST_TWO;
                    tail_data_d = s_data;
                    tail_last_d = s_last;
                end else if (w_accept && w_winc) begin
                    head_data_d = s_data;
                    head_last_d = s_last;
                end else if (w_winc) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_winc) begin
                    state_d     = ST_ONE;
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        word_cnt_d  = word_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (w_winc) begin
            word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
            if (head_last_q) begin
                pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            end
        end
        // Saturate rather than wrap so a long stall is never under-reported.
        if (w_stall && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q     <= ST_EMPTY;
            head_data_q <= '0;
            head_last_q <= 1'b0;
            tail_data_q <= '0;
            tail_last_q <= 1'b0;
            word_cnt_q  <= '0;
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            tail_data_q <= tail_data_d;
            tail_last_q <= tail_last_d;
            word_cnt_q  <= word_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_stream_adapter
// Purpose  : Directed self-checking bench for fifo_wr_stream_adapter. A
//            second instance with 4-bit counters exercises counter
//            saturation and wrap in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_stream_adapter;

    logic        wclk;
    logic        wrst_n;
    logic        s_valid, s_last, s_ready, wen, wfull, winc;
    logic [7:0]  s_data, wdata;
    logic [15:0] word_cnt, pkt_cnt, stall_cnt;

    logic        s_valid_s, s_last_s, s_ready_s, wen_s, wfull_s, winc_s;
    logic [7:0]  s_data_s, wdata_s;
    logic [3:0]  word_cnt_s, pkt_cnt_s, stall_cnt_s;

    int checks;
    int errors;

    fifo_wr_stream_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .wclk(wclk), .wrst_n(wrst_n),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .wen(wen), .wfull(wfull), .winc(winc), .wdata(wdata),
        .word_cnt(word_cnt), .pkt_cnt(pkt_cnt), .stall_cnt(stall_cnt)
    );

    fifo_wr_stream_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_s (
        .wclk(wclk), .wrst_n(wrst_n),
        .s_valid(s_valid_s), .s_data(s_data_s), .s_last(s_last_s), .s_ready(s_ready_s),
        .wen(wen_s), .wfull(wfull_s), .winc(winc_s), .wdata(wdata_s),
        .word_cnt(word_cnt_s), .pkt_cnt(pkt_cnt_s), .stall_cnt(stall_cnt_s)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Inputs change at posedge+1; comparisons happen at posedge+2.
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        checks++; if (winc !== 1'b0) begin errors++; $display("FAIL reset_winc got=%b exp=0", winc); end
        checks++; if (wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got=%h exp=00", wdata); end
        checks++; if ({word_cnt, pkt_cnt, stall_cnt} !== 48'h0) begin errors++;
            $display("FAIL reset_counters got=%h/%h/%h exp=0/0/0", word_cnt, pkt_cnt, stall_cnt); end
        tick();
        wrst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic exp_w;
        wen = 1'b1; wfull = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            s_valid = (k < 16);
            s_data  = (k < 16) ? 8'(k + 1) : 8'h00;
            s_last  = (k == 15);
            exp_w   = (k >= 1) && (k <= 16);
            #1;
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL stream_s_ready cyc=%0d got=%b exp=1", k, s_ready); end
            checks++; if (winc !== exp_w) begin errors++; $display("FAIL stream_winc cyc=%0d got=%b exp=%b", k, winc, exp_w); end
            if (exp_w) begin
                checks++; if (wdata !== 8'(k)) begin errors++; $display("FAIL stream_wdata cyc=%0d got=%h exp=%h", k, wdata, 8'(k)); end
            end
            tick();
        end
        checks++; if ({word_cnt, pkt_cnt, stall_cnt} !== {16'd16, 16'd1, 16'd0}) begin errors++;
            $display("FAIL stream_counters got=%0d/%0d/%0d exp=16/1/0", word_cnt, pkt_cnt, stall_cnt); end
    endtask

    task automatic test_full_stall();
        logic [10:0] v   = 11'b00111111111; // bit c = cycle c
        logic [10:0] wf  = 11'b00001111100;
        logic [10:0] rdy = 11'b11100000111;
        logic [10:0] wi  = 11'b01110000010;
        logic [7:0]  d   [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h24, 8'h24, 8'h24, 8'h24, 8'h24, 8'h00, 8'h00};
        logic [7:0]  wd  [11] = '{8'h00, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22, 8'h23, 8'h24, 8'h00};
        wen = 1'b1; s_last = 1'b0;
        for (int c = 0; c < 11; c++) begin
            s_valid = v[c]; s_data = d[c]; wfull = wf[c];
            #1;
            checks++; if (s_ready !== rdy[c]) begin errors++; $display("FAIL stall_s_ready cyc=%0d got=%b exp=%b", c, s_ready, rdy[c]); end
            checks++; if (winc !== wi[c]) begin errors++; $display("FAIL stall_winc cyc=%0d got=%b exp=%b", c, winc, wi[c]); end
            if (wi[c]) begin
                checks++; if (wdata !== wd[c]) begin errors++; $display("FAIL stall_wdata cyc=%0d got=%h exp=%h", c, wdata, wd[c]); end
            end
            tick();
        end
        checks++; if ({word_cnt, pkt_cnt, stall_cnt} !== {16'd20, 16'd1, 16'd5}) begin errors++;
            $display("FAIL stall_counters got=%0d/%0d/%0d exp=20/1/5", word_cnt, pkt_cnt, stall_cnt); end
    endtask

    task automatic test_back_to_back();
        logic exp_w;
        wen = 1'b1; wfull = 1'b0;
        for (int j = 0; j <= 11; j++) begin
            s_valid = (j <= 10);
            s_data  = 8'(8'h40 + j);
            s_last  = (j == 10);
            exp_w   = (j >= 1);
            #1;
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_s_ready cyc=%0d got=%b exp=1", j, s_ready); end
            checks++; if (winc !== exp_w) begin errors++; $display("FAIL b2b_winc cyc=%0d got=%b exp=%b", j, winc, exp_w); end
            if (exp_w) begin
                checks++; if (wdata !== 8'(8'h40 + j - 1)) begin errors++;
                    $display("FAIL b2b_wdata cyc=%0d got=%h exp=%h", j, wdata, 8'(8'h40 + j - 1)); end
            end
            if (j == 11) begin
                checks++; if (word_cnt !== 16'd30) begin errors++; $display("FAIL b2b_word_cnt10 got=%0d exp=30", word_cnt); end
            end
            tick();
        end
        checks++; if ({word_cnt, pkt_cnt, stall_cnt} !== {16'd31, 16'd2, 16'd5}) begin errors++;
            $display("FAIL b2b_counters got=%0d/%0d/%0d exp=31/2/5", word_cnt, pkt_cnt, stall_cnt); end
    endtask

    task automatic test_wen_pause();
        logic [7:0] v   = 8'b00111111;
        logic [7:0] we  = 8'b11110000;
        logic [7:0] wf  = 8'b00001110;
        logic [7:0] rdy = 8'b11100011;
        logic [7:0] wi  = 8'b01110000;
        logic [7:0] d   [8] = '{8'h51, 8'h52, 8'h53, 8'h53, 8'h53, 8'h53, 8'h00, 8'h00};
        logic [7:0] wd  [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h51, 8'h52, 8'h53, 8'h00};
        s_last = 1'b0;
        for (int c = 0; c < 8; c++) begin
            s_valid = v[c]; s_data = d[c]; wen = we[c]; wfull = wf[c];
            #1;
            checks++; if (s_ready !== rdy[c]) begin errors++; $display("FAIL wen_s_ready cyc=%0d got=%b exp=%b", c, s_ready, rdy[c]); end
            checks++; if (winc !== wi[c]) begin errors++; $display("FAIL wen_winc cyc=%0d got=%b exp=%b", c, winc, wi[c]); end
            if (wi[c]) begin
                checks++; if (wdata !== wd[c]) begin errors++; $display("FAIL wen_wdata cyc=%0d got=%h exp=%h", c, wdata, wd[c]); end
            end
            tick();
        end
        checks++; if ({word_cnt, pkt_cnt, stall_cnt} !== {16'd34, 16'd2, 16'd5}) begin errors++;
            $display("FAIL wen_counters got=%0d/%0d/%0d exp=34/2/5", word_cnt, pkt_cnt, stall_cnt); end
    endtask

    task automatic test_reset_midop();
        wen = 1'b0; wfull = 1'b0; s_last = 1'b0;
        s_valid = 1'b1; s_data = 8'hAA; tick();
        s_data = 8'hBB; tick();
        s_valid = 1'b0; s_data = 8'h00;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midrst_pre_s_ready got=%b exp=0", s_ready); end
        checks++; if (wdata !== 8'hAA) begin errors++; $display("FAIL midrst_pre_wdata got=%h exp=aa", wdata); end
        wen = 1'b1;
        wrst_n = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL midrst_s_ready got=%b exp=1", s_ready); end
        checks++; if (winc !== 1'b0) begin errors++; $display("FAIL midrst_winc got=%b exp=0", winc); end
        checks++; if (wdata !== 8'h00) begin errors++; $display("FAIL midrst_wdata got=%h exp=00", wdata); end
        checks++; if ({word_cnt, pkt_cnt, stall_cnt} !== 48'h0) begin errors++;
            $display("FAIL midrst_counters got=%0d/%0d/%0d exp=0/0/0", word_cnt, pkt_cnt, stall_cnt); end
        tick();
        wrst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (winc !== 1'b0) begin errors++; $display("FAIL midrst_post_winc cyc=%0d got=%b exp=0", c, winc); end
            tick();
        end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL midrst_post_word_cnt got=%0d exp=0", word_cnt); end
    endtask

    task automatic test_saturate_wrap();
        wen_s = 1'b1; wfull_s = 1'b1; s_last_s = 1'b0;
        s_valid_s = 1'b1; s_data_s = 8'h01;
        #1;
        checks++; if (winc_s !== 1'b0) begin errors++; $display("FAIL sat_first_winc got=%b exp=0", winc_s); end
        tick();
        s_valid_s = 1'b0; s_data_s = 8'h00;
        for (int n = 1; n <= 17; n++) begin
            #1;
            checks++; if (winc_s !== 1'b0) begin errors++; $display("FAIL sat_winc cyc=%0d got=%b exp=0", n, winc_s); end
            checks++; if (stall_cnt_s !== 4'((n - 1) > 15 ? 15 : (n - 1))) begin errors++;
                $display("FAIL sat_stall_cnt cyc=%0d got=%0d exp=%0d", n, stall_cnt_s, (n - 1) > 15 ? 15 : (n - 1)); end
            tick();
        end
        checks++; if (stall_cnt_s !== 4'hF) begin errors++; $display("FAIL sat_stall_hold got=%h exp=f", stall_cnt_s); end
        wfull_s = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_valid_s = (i <= 14);
            s_data_s  = 8'(i + 2);
            #1;
            checks++; if (winc_s !== 1'b1) begin errors++; $display("FAIL wrap_winc cyc=%0d got=%b exp=1", i, winc_s); end
            checks++; if (wdata_s !== 8'(i + 1)) begin errors++; $display("FAIL wrap_wdata cyc=%0d got=%h exp=%h", i, wdata_s, 8'(i + 1)); end
            checks++; if (word_cnt_s !== 4'(i)) begin errors++; $display("FAIL wrap_word_cnt cyc=%0d got=%0d exp=%0d", i, word_cnt_s, i); end
            tick();
        end
        s_valid_s = 1'b0;
        checks++; if (word_cnt_s !== 4'h0) begin errors++; $display("FAIL wrap_word_cnt_zero got=%h exp=0", word_cnt_s); end
        checks++; if (stall_cnt_s !== 4'hF) begin errors++; $display("FAIL sat_stall_after got=%h exp=f", stall_cnt_s); end
    endtask

    initial begin
        checks = 0; errors = 0;
        wrst_n = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; wen = 1'b1; wfull = 1'b0;
        s_valid_s = 1'b0; s_data_s = 8'h00; s_last_s = 1'b0; wen_s = 1'b1; wfull_s = 1'b0;
        test_reset();
        test_stream();
        test_full_stall();
        test_back_to_back();
        test_wen_pause();
        test_reset_midop();
        test_saturate_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
